sample_scheduler: RTL and testbench
===================================

// Module: sample_scheduler
// PURPOSE
//  Paces the dual-channel (voltage/current) ADC sampler at a programmable rate and averages
//  2**LOG2_N sample pairs per window. Produces averaged V, I and V*I (power) per window.
//  Flags overruns and sampler hangs. Sits between the control/register logic and the sampler.
// PARAMETERS
//  DW        12    ADC code width per channel
//  PERIOD_W  16    width of sample-period register
//  LOG2_N    4     log2 of samples per averaging window (N = 16)
//  TIMEOUT   1024  max cycles to wait for each sampler busy edge before declaring a hang
// PORTS
//  clk        in   1            system clock
//  rst        in   1            asynchronous reset, active-high
//  enable     in   1            1 = run periodic sampling, 0 = stop after current conversion
//  period     in   PERIOD_W     sample period in clk cycles; loaded on each tick / enable rise
//  smp_start  out  1            one-cycle start pulse to sampler
//  smp_busy   in   1            sampler busy
//  smp_data   in   2*DW         sampler result: [2*DW-1:DW] = voltage, [DW-1:0] = current
//  win_valid  out  1            one-cycle pulse: window averages valid
//  avg_v      out  DW           window mean voltage code
//  avg_i      out  DW           window mean current code
//  avg_p      out  2*DW         window mean of V*I products
//  overrun    out  1            one-cycle pulse: tick dropped because a conversion was in flight
//  hang       out  1            one-cycle pulse: sampler timeout
//  ovr_cnt    out  8            saturating overrun count
//  hang_cnt   out  8            saturating hang count
// BEHAVIOUR
//  Reset: all outputs 0, counters 0, accumulators 0, FSM IDLE, period timer 0.
//  Timer: on enable 0->1 load P=period, first tick P cycles later; then tick every P cycles,
//   reloading period at each tick. P=0 or P=1 -> tick every cycle. Timer held at 0 while !enable.
//  FSM:
//   IDLE      : enable=1 -> ARMED (timer loaded same edge).
//   ARMED     : tick & !smp_busy -> smp_start=1 for exactly 1 cycle, -> WAIT_BUSY.
//               tick & smp_busy -> overrun pulse, stay ARMED. enable=0 -> IDLE.
//   WAIT_BUSY : smp_busy=1 -> WAIT_DONE. TIMEOUT cycles without it -> HANG.
//   WAIT_DONE : smp_busy=0 -> capture smp_data that cycle, accumulate, -> ARMED (or IDLE if
//               enable=0). TIMEOUT cycles still busy -> HANG.
//   HANG      : hang pulse, hang_cnt+1 (sat 255), sample discarded, -> ARMED/IDLE.
//  Tick while in WAIT_BUSY/WAIT_DONE: dropped, overrun pulse, ovr_cnt+1 (sat 255).
//  Timeout counter restarts on entry to WAIT_BUSY and to WAIT_DONE.
//  Accumulate: sum_v += V, sum_i += I (DW+LOG2_N bits), sum_p += V*I (2*DW+LOG2_N bits),
//   unsigned; sample counter LOG2_N bits, wraps.
//  On Nth capture: avg_* = sum_* >> LOG2_N (truncate, incl. final sample), win_valid=1 next
//   cycle, sums and counter clear same edge; avg_* hold until next window.
//  Capture with count wrap and new tick same cycle: both honoured (tick handled in ARMED next).
//  enable 0 mid-window: in-flight conversion completes (not aborted); partial window discarded,
//   sums/counter cleared on entry to IDLE; avg_* keep last completed window.
//  Async reset mid-conversion: smp_start drops immediately; sampler busy ignored until ARMED.
// TESTING
//  1 period=100, sampler model busy 30 cyc, V=0x800 I=0x100 const -> smp_start every 100 cyc;
//    after 16 samples win_valid, avg_v=0x800, avg_i=0x100, avg_p=0x080000.
//  2 V ramps 0..15, I=2 -> avg_v=7 (120>>4), avg_i=2, avg_p=15 (240>>4).
//  3 period=20, busy 30 cyc -> overrun pulse each dropped tick, ovr_cnt saturates at 255.
//  4 sampler never asserts busy -> hang after TIMEOUT cycles, hang_cnt=1, no win_valid, resumes.
//  5 enable=0 after 5 samples -> conversion finishes, FSM IDLE, no win_valid; re-enable ->
//    fresh 16-sample window from zero.
//  6 rst pulse mid WAIT_DONE -> all outputs 0 next edge, ovr_cnt/hang_cnt 0, FSM IDLE.

Source files
------------

// File: rtl/sample_scheduler_if.sv
// Sampler-side bus of the sample scheduler: start pulse out,
// busy and dual-channel result back.
interface sample_scheduler_if #(
    parameter int DW = 12
);
    logic            smp_start;
    logic            smp_busy;
    logic [2*DW-1:0] smp_data;

    modport master (output smp_start, input smp_busy, input smp_data);
    modport slave  (input smp_start, output smp_busy, output smp_data);
endinterface

// File: rtl/sample_scheduler.sv
// Paces a V/I ADC sampler, averages 2**LOG2_N pairs per window,
// and reports mean V, I and V*I plus overrun/hang events.
module sample_scheduler #(
    parameter int DW       = 12,
    parameter int PERIOD_W = 16,
    parameter int LOG2_N   = 4,
    parameter int TIMEOUT  = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    sample_scheduler_if.master  smp,
    output logic                win_valid,
    output logic [DW-1:0]       avg_v,
    output logic [DW-1:0]       avg_i,
    output logic [2*DW-1:0]     avg_p,
    output logic                overrun,
    output logic                hang,
    output logic [7:0]          ovr_cnt,
    output logic [7:0]          hang_cnt
);
    localparam int SW = DW + LOG2_N;
    localparam int PW = 2 * DW + LOG2_N;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, ARMED, WAIT_BUSY, WAIT_DONE, HANG
    } state_t;

    state_t state_q, state_d;
    logic en_q;
    logic [PERIOD_W-1:0] tmr_q, tmr_d;
    logic [TW-1:0] to_q, to_d;
    logic [LOG2_N-1:0] cnt_q, cnt_d;
    logic [SW-1:0] sum_v_q, sum_v_d, sum_i_q, sum_i_d;
    logic [PW-1:0] sum_p_q, sum_p_d;
    logic [DW-1:0] avg_v_q, avg_v_d, avg_i_q, avg_i_d;
    logic [2*DW-1:0] avg_p_q, avg_p_d;
    logic start_q, start_d, win_q, win_d;
    logic ovr_q, ovr_d, hang_q, hang_d;
    logic [7:0] ovr_cnt_q, ovr_cnt_d, hang_cnt_q, hang_cnt_d;

    logic tick, clr;
    logic [DW-1:0] v_in, i_in;
    logic [2*DW-1:0] prod;
    logic [SW-1:0] sv_n, si_n;
    logic [PW-1:0] sp_n;

    assign v_in = smp.smp_data[2*DW-1:DW];
    assign i_in = smp.smp_data[DW-1:0];
    assign prod = (2*DW)'(v_in) * (2*DW)'(i_in);
    assign sv_n = sum_v_q + SW'(v_in);
    assign si_n = sum_i_q + SW'(i_in);
    assign sp_n = sum_p_q + PW'(prod);

    always_comb begin
        tick       = enable && en_q && (tmr_q <= PERIOD_W'(1));
        state_d    = state_q;
        to_d       = to_q;
        cnt_d      = cnt_q;
        sum_v_d    = sum_v_q;
        sum_i_d    = sum_i_q;
        sum_p_d    = sum_p_q;
        avg_v_d    = avg_v_q;
        avg_i_d    = avg_i_q;
        avg_p_d    = avg_p_q;
        start_d    = 1'b0;
        win_d      = 1'b0;
        ovr_d      = 1'b0;
        hang_d     = 1'b0;
        ovr_cnt_d  = ovr_cnt_q;
        hang_cnt_d = hang_cnt_q;
        clr        = 1'b0;

        if (!enable)
            tmr_d = '0;
        else if (!en_q || tick)
            tmr_d = period;
        else
            tmr_d = tmr_q - PERIOD_W'(1);

        case (state_q)
            IDLE: begin
                if (enable) state_d = ARMED;
            end
            ARMED: begin
                if (!enable) begin
                    state_d = IDLE;
                    clr     = 1'b1;
                end else if (tick) begin
                    if (smp.smp_busy) begin
                        ovr_d = 1'b1;
                    end else begin
                        start_d = 1'b1;
                        to_d    = '0;
                        state_d = WAIT_BUSY;
                    end
                end
            end
            WAIT_BUSY: begin
                ovr_d = tick;
                if (smp.smp_busy) begin
                    state_d = WAIT_DONE;
                    to_d    = '0;
                end else if (to_q == TO_LAST) begin
                    state_d = HANG;
                    hang_d  = 1'b1;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            WAIT_DONE: begin
                ovr_d = tick;
                if (!smp.smp_busy) begin
                    // last sample of the window folds straight into the mean
                    if (cnt_q == '1) begin
                        avg_v_d = DW'(sv_n >> LOG2_N);
                        avg_i_d = DW'(si_n >> LOG2_N);
                        avg_p_d = (2*DW)'(sp_n >> LOG2_N);
                        win_d   = 1'b1;
                        sum_v_d = '0;
                        sum_i_d = '0;
                        sum_p_d = '0;
                        cnt_d   = '0;
                    end else begin
                        sum_v_d = sv_n;
                        sum_i_d = si_n;
                        sum_p_d = sp_n;
                        cnt_d   = cnt_q + LOG2_N'(1);
                    end
                    state_d = enable ? ARMED : IDLE;
                    clr     = !enable;
                end else if (to_q == TO_LAST) begin
                    state_d = HANG;
                    hang_d  = 1'b1;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            HANG: begin
                ovr_d   = tick;
                state_d = enable ? ARMED : IDLE;
                clr     = !enable;
            end
            default: state_d = IDLE;
        endcase

        if (ovr_d && ovr_cnt_q != 8'hFF)
            ovr_cnt_d = ovr_cnt_q + 8'd1;
        if (hang_d && hang_cnt_q != 8'hFF)
            hang_cnt_d = hang_cnt_q + 8'd1;
        // partial windows never survive a return to IDLE
        if (clr) begin
            sum_v_d = '0;
            sum_i_d = '0;
            sum_p_d = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            en_q       <= 1'b0;
            tmr_q      <= '0;
            to_q       <= '0;
            cnt_q      <= '0;
            sum_v_q    <= '0;
            sum_i_q    <= '0;
            sum_p_q    <= '0;
            avg_v_q    <= '0;
            avg_i_q    <= '0;
            avg_p_q    <= '0;
            start_q    <= 1'b0;
            win_q      <= 1'b0;
            ovr_q      <= 1'b0;
            hang_q     <= 1'b0;
            ovr_cnt_q  <= '0;
            hang_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            en_q       <= enable;
            tmr_q      <= tmr_d;
            to_q       <= to_d;
            cnt_q      <= cnt_d;
            sum_v_q    <= sum_v_d;
            sum_i_q    <= sum_i_d;
            sum_p_q    <= sum_p_d;
            avg_v_q    <= avg_v_d;
            avg_i_q    <= avg_i_d;
            avg_p_q    <= avg_p_d;
            start_q    <= start_d;
            win_q      <= win_d;
            ovr_q      <= ovr_d;
            hang_q     <= hang_d;
            ovr_cnt_q  <= ovr_cnt_d;
            hang_cnt_q <= hang_cnt_d;
        end
    end

    assign smp.smp_start = start_q;
    assign win_valid     = win_q;
    assign avg_v         = avg_v_q;
    assign avg_i         = avg_i_q;
    assign avg_p         = avg_p_q;
    assign overrun       = ovr_q;
    assign hang          = hang_q;
    assign ovr_cnt       = ovr_cnt_q;
    assign hang_cnt      = hang_cnt_q;
endmodule

// File: tb/tb_sample_scheduler.sv
// Scoreboard bench for sample_scheduler: sampler model feeds a
// window-average reference; a monitor pops and compares each window.
module tb_sample_scheduler;
    localparam int DW = 12;
    localparam int PW = 16;
    localparam int LN = 4;
    localparam int TO = 1024;
    localparam int N  = 1 << LN;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enable = 1'b0;
    logic [PW-1:0] period = '0;
    logic win_valid, overrun, hang;
    logic [DW-1:0] avg_v, avg_i;
    logic [2*DW-1:0] avg_p;
    logic [7:0] ovr_cnt, hang_cnt;

    sample_scheduler_if #(.DW(DW)) sif ();

    sample_scheduler #(
        .DW(DW), .PERIOD_W(PW), .LOG2_N(LN), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .period(period),
        .smp(sif), .win_valid(win_valid), .avg_v(avg_v),
        .avg_i(avg_i), .avg_p(avg_p), .overrun(overrun),
        .hang(hang), .ovr_cnt(ovr_cnt), .hang_cnt(hang_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act,
                       input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    typedef struct {
        longint v;
        longint i;
        longint p;
    } win_t;

    win_t expq[$];
    longint mv[$];
    longint mi[$];

    // Reference: window mean is the plain integer mean of N captured pairs.
    function automatic void model_push(longint v, longint i);
        win_t w;
        longint sv, si, sp;
        mv.push_back(v);
        mi.push_back(i);
        if (mv.size() == N) begin
            sv = 0; si = 0; sp = 0;
            for (int k = 0; k < N; k++) begin
                sv += mv[k];
                si += mi[k];
                sp += mv[k] * mi[k];
            end
            w.v = sv / N;
            w.i = si / N;
            w.p = sp / N;
            expq.push_back(w);
            mv.delete();
            mi.delete();
        end
    endfunction

    // Sampler model
    int mode = 0;
    int busy_len = 30;
    bit rand_busy = 0;
    int ramp = 0;
    bit orphan = 0;
    int captured = 0;
    logic [DW-1:0] sv_val, si_val;
    int b;

    initial begin
        sif.smp_busy = 1'b0;
        sif.smp_data = '0;
        forever begin
            @(negedge clk);
            if (sif.smp_start === 1'b1 && mode != 3) begin
                case (mode)
                    0: begin sv_val = 12'h800; si_val = 12'h100; end
                    1: begin sv_val = DW'(ramp); si_val = 12'd2; ramp++; end
                    default: begin
                        sv_val = DW'($urandom);
                        si_val = DW'($urandom);
                    end
                endcase
                b = rand_busy ? int'($urandom_range(3, 20)) : busy_len;
                orphan = 0;
                sif.smp_busy = 1'b1;
                repeat (b) @(negedge clk);
                sif.smp_data = {sv_val, si_val};
                sif.smp_busy = 1'b0;
                if (!orphan) begin
                    model_push(sv_val, si_val);
                    captured++;
                end
            end
        end
    end

    // Monitor
    int wins = 0, nstart = 0, novr = 0, nhang = 0;
    int last_start = -1;
    int en_cyc = 0;
    bit first_pending = 0;
    int iv_exp = 0;
    bit start_prev = 0;
    longint last_v, last_i, last_p;
    win_t w;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (win_valid) begin
                    wins++;
                    last_v = avg_v;
                    last_i = avg_i;
                    last_p = avg_p;
                    if (expq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL win_unexpected: got win_valid=1 expected 0 at cycle %0d", cyc);
                    end else begin
                        w = expq.pop_front();
                        chk("avg_v", avg_v, w.v);
                        chk("avg_i", avg_i, w.i);
                        chk("avg_p", avg_p, w.p);
                    end
                end
                if (sif.smp_start) begin
                    chk("start_width", start_prev, 0);
                    if (first_pending)
                        chk("first_start_lat", cyc - en_cyc, period + 1);
                    else if (iv_exp > 0 && last_start >= 0)
                        chk("start_interval", cyc - last_start, iv_exp);
                    first_pending = 0;
                    last_start = cyc;
                    nstart++;
                end
                start_prev = sif.smp_start;
                if (overrun) novr++;
                if (hang) begin
                    nhang++;
                    chk("hang_latency", cyc - last_start, TO);
                end
            end else begin
                start_prev = 0;
            end
        end
    end

    task automatic start_run(input int p);
        @(negedge clk);
        period = PW'(p);
        enable = 1'b1;
        en_cyc = cyc;
        last_start = -1;
        first_pending = 1;
    endtask

    task automatic stop_run();
        @(negedge clk);
        enable = 1'b0;
        repeat (60) @(negedge clk);
        chk("quiesce_busy", sif.smp_busy, 0);
        repeat (5) @(negedge clk);
        mv.delete();
        mi.delete();
        ramp = 0;
    endtask

    task automatic wait_win(input int n, input int budget);
        int w0;
        w0 = wins;
        for (int k = 0; k < budget && wins < w0 + n; k++)
            @(negedge clk);
        chk("win_arrived", wins >= w0 + n, 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_start"}, sif.smp_start, 0);
        chk({tag, "_win"}, win_valid, 0);
        chk({tag, "_avg_v"}, avg_v, 0);
        chk({tag, "_avg_i"}, avg_i, 0);
        chk({tag, "_avg_p"}, avg_p, 0);
        chk({tag, "_ovr"}, overrun, 0);
        chk({tag, "_hang"}, hang, 0);
        chk({tag, "_ovr_cnt"}, ovr_cnt, 0);
        chk({tag, "_hang_cnt"}, hang_cnt, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, c0, h0, o0, d;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero("rst");
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk_zero("idle");

        // constant V/I, period 100, busy 30
        mode = 0; busy_len = 30; rand_busy = 0; iv_exp = 100;
        start_run(100);
        wait_win(1, 2500);
        chk("t1_avg_v", last_v, 12'h800);
        chk("t1_avg_i", last_i, 12'h100);
        chk("t1_avg_p", last_p, 24'h080000);
        iv_exp = 0;
        stop_run();

        // ramp V 0..15, I=2
        mode = 1; busy_len = 10;
        start_run(40);
        wait_win(1, 1200);
        chk("t2_avg_v", last_v, 7);
        chk("t2_avg_i", last_i, 2);
        chk("t2_avg_p", last_p, 15);
        stop_run();

        // random data, random periods and busy lengths
        mode = 2; rand_busy = 1;
        start_run($urandom_range(30, 80));
        wait_win(3, 5000);
        stop_run();

        // sampler never raises busy
        mode = 3;
        h0 = nhang;
        start_run(1500);
        for (int k = 0; k < 3000 && nhang == h0; k++) @(negedge clk);
        chk("hang_seen", nhang - h0, 1);
        chk("hang_cnt", hang_cnt, 1);
        mode = 2;
        c0 = captured;
        for (int k = 0; k < 4000 && captured == c0; k++) @(negedge clk);
        chk("resume_after_hang", captured > c0, 1);
        stop_run();

        // disable after 5 samples while 6th is in flight
        c0 = captured;
        start_run(40);
        for (int k = 0; k < 1000 && captured < c0 + 5; k++) @(negedge clk);
        s0 = nstart;
        for (int k = 0; k < 200 && nstart == s0; k++) @(negedge clk);
        chk("t5_sixth_start", nstart - s0, 1);
        c0 = captured;
        enable = 1'b0;
        s0 = nstart;
        repeat (300) @(negedge clk);
        chk("t5_inflight_done", captured - c0, 1);
        chk("t5_no_start", nstart - s0, 0);
        mv.delete();
        mi.delete();
        start_run(40);
        wait_win(1, 1500);
        stop_run();

        // overruns: period 20, busy 30
        rand_busy = 0; busy_len = 30;
        chk("t3_ovr_cnt0", ovr_cnt, 0);
        o0 = novr;
        start_run(20);
        repeat (2000) @(negedge clk);
        d = novr - o0;
        chk("t3_ovr_cnt_track", ovr_cnt, d);
        chk("t3_ovr_rate", (d >= 48 && d <= 52), 1);
        repeat (10000) @(negedge clk);
        chk("t3_ovr_sat", ovr_cnt, 255);
        chk("t3_ovr_many", (novr - o0) > 255, 1);

        // async reset while in WAIT_DONE
        s0 = nstart;
        for (int k = 0; k < 100 && nstart == s0; k++) @(negedge clk);
        repeat (10) @(negedge clk);
        chk("t6_busy_high", sif.smp_busy, 1);
        #2;
        rst = 1'b1;
        orphan = 1;
        enable = 1'b0;
        #1;
        chk_zero("t6");
        mv.delete();
        mi.delete();
        expq.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        s0 = nstart;
        repeat (40) @(negedge clk);
        chk("t6_no_start", nstart - s0, 0);
        chk("t6_ovr_cnt", ovr_cnt, 0);
        chk("t6_busy_done", sif.smp_busy, 0);
        mode = 2; rand_busy = 1;
        start_run(40);
        wait_win(1, 1500);
        stop_run();

        chk("leftover_windows", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
